// File: rtl/ro_fetch_arbiter_pkg.sv
// Purpose: shared constants, FSM encoding and range-check helper for the weight-ROM fetch arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ro_fetch_arbiter_pkg;

  localparam int D_WL      = 24;                 // bits per unit weight
  localparam int UNITS_NUM = 5;                  // weights per ROM row
  localparam int ROW_W     = UNITS_NUM * D_WL;   // one ROM row
  localparam int DEPTH     = 180;                // ROM rows
  localparam int AW        = 8;                  // ROM address width
  localparam int IDW       = 2;                  // requester id width
  localparam int NREQ_DEF  = 2;                  // default requester count

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // A burst is out of range when its end row passes DEPTH. The sum is taken
  // one bit wider than AW so base=255,len=255 cannot wrap into range.
  function automatic logic range_bad(input logic [AW-1:0] base, input logic [AW-1:0] len);
    logic [AW:0] sum;
    sum = {1'b0, base} + {1'b0, len};
    return (sum > (AW+1)'(DEPTH));
  endfunction

endpackage

// File: rtl/ro_fetch_arbiter_if.sv
// Purpose: bundles requester, ROM and output-stream signals of the fetch arbiter.
// Latency: n/a (wiring only).
// Backpressure: out_ready throttles the output stream; req_valid held until req_ready.
// Ports: slave = arbiter view, master = requester/ROM/sink view.
interface ro_fetch_arbiter_if #(
  parameter int NREQ = ro_fetch_arbiter_pkg::NREQ_DEF
);
  import ro_fetch_arbiter_pkg::*;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_base;
  logic [NREQ*AW-1:0] req_len;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      rom_addr;
  logic [ROW_W-1:0]   rom_data;
  logic               out_valid;
  logic               out_ready;
  logic [ROW_W-1:0]   out_data;
  logic [IDW-1:0]     out_id;
  logic               out_last;
  logic               done;
  logic               err;
  logic               busy;

  modport slave (
    input  req_valid, req_base, req_len, rom_data, out_ready,
    output req_ready, rom_addr, out_valid, out_data, out_id, out_last, done, err, busy
  );

  modport master (
    output req_valid, req_base, req_len, rom_data, out_ready,
    input  req_ready, rom_addr, out_valid, out_data, out_id, out_last, done, err, busy
  );

endinterface

// File: rtl/ro_fetch_arbiter_rr_arbiter.sv
// Purpose: round-robin pick of the first asserted request at or after ptr (cyclic).
// Latency: combinational.
// Backpressure: none; the parent decides when a grant is taken.
// Ports: req (request vector), ptr (priority start) -> grant (one-hot), gnt_idx, gnt_any.
module ro_fetch_arbiter_rr_arbiter
  import ro_fetch_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  int cand;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req[cand]) begin
        gnt_any     = 1'b1;
        grant[cand] = 1'b1;
        gnt_idx     = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/ro_fetch_arbiter.sv
// Purpose: shares the combinational weight ROM between NREQ requesters, streaming round-robin bursts.
// Latency: first beat registered 1 cycle after accept, then 1 row/cycle; 1 idle cycle between bursts.
// Backpressure: out_ready stalls the registered output stage; requests wait (req_ready=0) during a burst.
// Ports: clk, rst (async, active-high); bus (slave modport) carries requests, ROM port and output stream.
module ro_fetch_arbiter
  import ro_fetch_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic             clk,
  input  logic             rst,
  ro_fetch_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    remain_q, remain_d;
  logic             out_valid_q, out_valid_d;
  logic [ROW_W-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [AW-1:0]    sel_base;
  logic [AW-1:0]    sel_len;
  logic             issue;
  logic             last_hs;

  ro_fetch_arbiter_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_base = bus.req_base[int'(gnt_idx)*AW +: AW];
    sel_len  = bus.req_len[int'(gnt_idx)*AW +: AW];
    // A new row may enter the output register when it is empty or draining this cycle.
    issue    = (state_q == ST_BURST) && (remain_q != '0) && (!out_valid_q || bus.out_ready);
    last_hs  = (state_q == ST_BURST) && out_valid_q && bus.out_ready && out_last_q;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          rr_ptr_d = IDW'((int'(gnt_idx) + 1) % NREQ);
          id_d     = gnt_idx;
          if (range_bad(sel_base, sel_len)) begin
            err_d = 1'b1;
          end else if (sel_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_BURST;
            addr_d   = sel_base;
            remain_d = sel_len;
          end
        end
      end

      ST_BURST: begin
        if (issue) begin
          out_data_d  = bus.rom_data;
          out_valid_d = 1'b1;
          out_last_d  = (remain_q == AW'(1));
          remain_d    = remain_q - AW'(1);
          // Stop on the final row so rom_addr never points past the ROM.
          if (remain_q != AW'(1)) begin
            addr_d = addr_q + AW'(1);
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
        end
        if (last_hs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      remain_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // req_ready is gated by rst so every output reads 0 while reset is held.
  assign bus.req_ready = ((state_q == ST_IDLE) && !rst) ? grant : '0;
  assign bus.rom_addr  = addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = id_q;
  assign bus.out_last  = out_last_q;
  // Burst completion pulses with the last handshake; err/len==0 outcomes pulse a cycle after accept.
  assign bus.done      = done_q | last_hs;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q == ST_BURST);

endmodule

// File: tb/tb_ro_fetch_arbiter.sv
module tb_ro_fetch_arbiter;
  import ro_fetch_arbiter_pkg::*;

  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ro_fetch_arbiter_if #(.NREQ(NR)) bus ();
  ro_fetch_arbiter #(.NREQ(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [ROW_W-1:0] rom_row(input logic [AW-1:0] a);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int k = 0; k < UNITS_NUM; k++) r[k*D_WL +: D_WL] = {a, 8'(k), a ^ 8'h5A};
    return r;
  endfunction

  assign bus.rom_data = rom_row(bus.rom_addr);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_d(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- event monitor ----------------
  typedef struct { logic [ROW_W-1:0] data; int id; int last; int cyc; } beat_t;
  typedef struct { int id; int cyc; } ev_t;
  beat_t beats[$];
  ev_t   dones[$], errs[$], grants[$];

  bit               stall_prev = 1'b0;
  logic [ROW_W-1:0] data_prev;
  int               id_prev, last_prev;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_i("stall_valid", int'(bus.out_valid), 1);
        check_d("stall_data", bus.out_data, data_prev);
        check_i("stall_id", int'(bus.out_id), id_prev);
        check_i("stall_last", int'(bus.out_last), last_prev);
      end
      if (bus.out_valid && bus.out_ready)
        beats.push_back('{bus.out_data, int'(bus.out_id), int'(bus.out_last), cyc});
      if (bus.done) dones.push_back('{int'(bus.out_id), cyc});
      if (bus.err)  errs.push_back('{int'(bus.out_id), cyc});
      if (bus.req_ready != '0) begin
        int gi = 0;
        check_i("ready_onehot", $countones(bus.req_ready), 1);
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) gi = i;
        grants.push_back('{gi, cyc});
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      data_prev  = bus.out_data;
      id_prev    = int'(bus.out_id);
      last_prev  = int'(bus.out_last);
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    beats.delete(); dones.delete(); errs.delete(); grants.delete();
  endtask

  task automatic set_req(input int r, input int b, input int l);
    bus.req_base[r*AW +: AW] = AW'(b);
    bus.req_len[r*AW +: AW]  = AW'(l);
    bus.req_valid[r]         = 1'b1;
  endtask

  task automatic wait_grants(input int n);
    int t = 0;
    while (grants.size() < n && t < 400) begin @(negedge clk); #1; t++; end
    check_i("wait_grant", int'(grants.size() >= n), 1);
  endtask

  task automatic wait_ends(input int n);
    int t = 0;
    while (dones.size() + errs.size() < n && t < 400) begin @(negedge clk); #1; t++; end
    check_i("wait_end", int'(dones.size() + errs.size() >= n), 1);
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (beats.size() < n && t < 400) begin @(negedge clk); #1; t++; end
    check_i("wait_beat", int'(beats.size() >= n), 1);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    bus.req_valid = '0;
    step(); step();
    rst = 1'b0;
  endtask

  // ---------------- randomized phase: spec-level model ----------------
  typedef struct { int row; int id; int last; } exp_t;
  exp_t expq[$];
  int  mptr = 0;
  bit  mbusy = 0;
  bit  done_pend = 0, err_pend = 0;
  int  pend_id = 0;
  int  rb[NR], rl[NR];
  bit  holding[NR];
  int  granted_prev = 0;

  task automatic rand_cycle(input bit allow_new);
    int  exp_vec, exp_idx, exp_id;
    bit  exp_done, exp_err, nbusy;
    step();
    bus.out_ready = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int r = 0; r < NR; r++) begin
      if (granted_prev[r]) begin holding[r] = 0; bus.req_valid[r] = 1'b0; end
      if (allow_new && !holding[r] && $urandom_range(0, 2) == 0) begin
        int mode = $urandom_range(0, 9);
        if (mode == 0)      begin rb[r] = $urandom_range(0, 200);   rl[r] = 0; end
        else if (mode == 1) begin rb[r] = $urandom_range(170, 255); rl[r] = $urandom_range(11, 40); end
        else                begin rb[r] = $urandom_range(0, 179);   rl[r] = $urandom_range(1, 6); end
        set_req(r, rb[r], rl[r]);
        holding[r] = 1;
      end
    end
    @(negedge clk);
    exp_done = done_pend;
    exp_err  = err_pend;
    exp_id   = pend_id;
    nbusy    = mbusy;
    if (bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        check_i("extra_beat", 1, 0);
      end else begin
        exp_t e = expq.pop_front();
        check_d("rnd_data", bus.out_data, rom_row(AW'(e.row)));
        check_i("rnd_id", int'(bus.out_id), e.id);
        check_i("rnd_last", int'(bus.out_last), e.last);
        if (e.last != 0) begin exp_done = 1; exp_id = e.id; nbusy = 0; end
      end
    end
    check_i("rnd_busy", int'(bus.busy), int'(mbusy));
    check_i("rnd_done", int'(bus.done), int'(exp_done));
    check_i("rnd_err", int'(bus.err), int'(exp_err));
    if (exp_done || exp_err) check_i("rnd_ev_id", int'(bus.out_id), exp_id);
    if (!mbusy) check_i("rnd_idle_valid", int'(bus.out_valid), 0);
    exp_idx = -1;
    if (!mbusy)
      for (int k = 0; k < NR; k++)
        if (exp_idx < 0 && holding[(mptr + k) % NR]) exp_idx = (mptr + k) % NR;
    exp_vec = (exp_idx >= 0) ? (1 << exp_idx) : 0;
    check_i("rnd_grant", int'(bus.req_ready), exp_vec);
    done_pend = 0;
    err_pend  = 0;
    if (exp_idx >= 0) begin
      mptr    = (exp_idx + 1) % NR;
      pend_id = exp_idx;
      if (rb[exp_idx] + rl[exp_idx] > DEPTH) err_pend = 1;
      else if (rl[exp_idx] == 0) done_pend = 1;
      else begin
        nbusy = 1;
        for (int k = 0; k < rl[exp_idx]; k++)
          expq.push_back('{rb[exp_idx] + k, exp_idx, int'(k == rl[exp_idx] - 1)});
      end
    end
    granted_prev = exp_vec;
    mbusy = nbusy;
  endtask

  // ---------------- table vectors ----------------
  typedef struct { int r; int base; int len; int kind; int nbeats; } vec_t; // kind: 0 burst, 1 done, 2 err
  vec_t tbl[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, bp_pat[5];
    tbl[0] = '{0,  10,   4, 0,   4};
    tbl[1] = '{1, 176,   4, 0,   4};
    tbl[2] = '{0, 177,   4, 2,   0};
    tbl[3] = '{1,  50,   0, 1,   0};
    tbl[4] = '{0, 179,   1, 0,   1};
    tbl[5] = '{1, 180,   0, 1,   0};
    tbl[6] = '{0, 255, 255, 2,   0};
    tbl[7] = '{1,   0, 180, 0, 180};
    tbl[8] = '{0,   1, 180, 2,   0};
    bp_pat = '{1, 0, 0, 1, 1};

    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_base  = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check_i("rst_req_ready", int'(bus.req_ready), 0);
    check_i("rst_out_valid", int'(bus.out_valid), 0);
    check_d("rst_out_data", bus.out_data, '0);
    check_i("rst_misc", int'({bus.out_id, bus.out_last, bus.done, bus.err, bus.busy}), 0);
    check_i("rst_rom_addr", int'(bus.rom_addr), 0);
    bus.req_valid = '0;
    step();
    rst = 1'b0;

    // Single requests, out_ready high, against the table.
    foreach (tbl[i]) begin
      clear_logs();
      step();
      set_req(tbl[i].r, tbl[i].base, tbl[i].len);
      wait_grants(1);
      step();
      bus.req_valid = '0;
      wait_ends(1);
      step(); step();
      check_i("tbl_grants", grants.size(), 1);
      g = (grants.size() > 0) ? grants[0].cyc : 0;
      if (grants.size() > 0) check_i("tbl_grant_id", grants[0].id, tbl[i].r);
      check_i("tbl_nbeats", beats.size(), tbl[i].nbeats);
      check_i("tbl_ndone", dones.size(), int'(tbl[i].kind != 2));
      check_i("tbl_nerr", errs.size(), int'(tbl[i].kind == 2));
      foreach (beats[k]) begin
        check_d("tbl_data", beats[k].data, rom_row(AW'(tbl[i].base + k)));
        check_i("tbl_beat_id", beats[k].id, tbl[i].r);
        check_i("tbl_last", beats[k].last, int'(k == tbl[i].nbeats - 1));
        check_i("tbl_beat_cyc", beats[k].cyc, g + 2 + k);
      end
      if (dones.size() > 0) begin
        check_i("tbl_done_id", dones[0].id, tbl[i].r);
        check_i("tbl_done_cyc", dones[0].cyc, (tbl[i].kind == 0) ? g + 1 + tbl[i].nbeats : g + 1);
      end
      if (errs.size() > 0) begin
        check_i("tbl_err_id", errs[0].id, tbl[i].r);
        check_i("tbl_err_cyc", errs[0].cyc, g + 1);
      end
    end

    // Backpressure: out_ready 1,0,0,1,1 from the first valid cycle.
    clear_logs();
    step();
    set_req(0, 0, 3);
    wait_grants(1);
    g = (grants.size() > 0) ? grants[0].cyc : 0;
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 5; i++) begin step(); bus.out_ready = bp_pat[i][0]; end
    step();
    bus.out_ready = 1'b1;
    step(); step();
    check_i("bp_nbeats", beats.size(), 3);
    foreach (beats[k]) check_d("bp_data", beats[k].data, rom_row(AW'(k)));
    if (beats.size() == 3) begin
      check_i("bp_cyc0", beats[0].cyc, g + 2);
      check_i("bp_cyc1", beats[1].cyc, g + 5);
      check_i("bp_cyc2", beats[2].cyc, g + 6);
    end
    check_i("bp_ndone", dones.size(), 1);
    if (dones.size() > 0) check_i("bp_done_cyc", dones[0].cyc, g + 6);

    // Reset in the middle of a len=8 burst (rr_ptr is 1 here).
    clear_logs();
    step();
    set_req(0, 60, 8);
    wait_grants(1);
    step();
    bus.req_valid = '0;
    wait_beats(2);
    #2 rst = 1'b1;
    #1;
    check_i("mid_rst_valid", int'(bus.out_valid), 0);
    check_d("mid_rst_data", bus.out_data, '0);
    check_i("mid_rst_misc", int'({bus.out_id, bus.out_last, bus.done, bus.err, bus.busy}), 0);
    check_i("mid_rst_addr", int'(bus.rom_addr), 0);
    step(); step();
    rst = 1'b0;
    check_i("mid_rst_no_done", dones.size(), 0);
    clear_logs();
    step();
    set_req(0, 100, 1);
    set_req(1, 110, 1);
    wait_grants(1);
    if (grants.size() > 0) check_i("post_rst_first", grants[0].id, 0);
    step();
    bus.req_valid[0] = 1'b0;
    wait_grants(2);
    step();
    bus.req_valid[1] = 1'b0;
    wait_ends(2);
    step(); step();
    check_i("post_rst_nbeats", beats.size(), 2);
    if (beats.size() == 2 && grants.size() == 2) begin
      check_d("post_rst_d0", beats[0].data, rom_row(AW'(100)));
      check_d("post_rst_d1", beats[1].data, rom_row(AW'(110)));
      check_i("post_rst_ids", beats[0].id * 4 + beats[1].id, 1);
      check_i("post_rst_cyc", beats[0].cyc, grants[0].cyc + 2);
    end

    // Round-robin with both requesters held continuously.
    do_reset();
    clear_logs();
    step();
    set_req(0, 20, 2);
    set_req(1, 40, 2);
    wait_grants(4);
    step();
    bus.req_valid = '0;
    wait_ends(4);
    step(); step();
    check_i("rr_ngrants", grants.size(), 4);
    check_i("rr_nbeats", beats.size(), 8);
    if (grants.size() == 4 && dones.size() == 4 && beats.size() == 8) begin
      for (int k = 0; k < 4; k++) begin
        check_i("rr_order", grants[k].id, k % 2);
        check_i("rr_done_id", dones[k].id, k % 2);
        if (k > 0) check_i("rr_bubble", grants[k].cyc, dones[k-1].cyc + 1);
        for (int j = 0; j < 2; j++) begin
          check_d("rr_data", beats[2*k+j].data, rom_row(AW'(((k % 2) ? 40 : 20) + j)));
          check_i("rr_beat_id", beats[2*k+j].id, k % 2);
        end
      end
    end

    // Randomized traffic against the behavioural model.
    do_reset();
    mptr = 0; mbusy = 0; done_pend = 0; err_pend = 0; granted_prev = 0;
    expq.delete();
    for (int r = 0; r < NR; r++) holding[r] = 0;
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 300 && (mbusy || expq.size() != 0 || holding[0] || holding[1]
                                || done_pend || err_pend); i++)
      rand_cycle(1'b0);
    check_i("rnd_drained", expq.size(), 0);
    check_i("rnd_holding", int'(holding[0]) + int'(holding[1]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
